// File: rtl/mt48lc16m16a2.sv
// mt48lc16m16a2: functional SDR SDRAM model with bank/row tracking, sequential bursts, CAS latency and DQM
module mt48lc16m16a2 #(
    parameter int COL_BITS = 9,
    parameter int ROW_BITS = 13,
    parameter int MEM_AW   = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Cke,
    input  logic        Cs_n,
    input  logic        Ras_n,
    input  logic        Cas_n,
    input  logic        We_n,
    input  logic [1:0]  Ba,
    input  logic [12:0] Addr,
    input  logic [1:0]  Dqm,
    inout  wire  [15:0] Dq
);
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_BST = 4'b0110;

    logic [15:0]         mem_q [2**MEM_AW];
    logic [3:0]          open_q, open_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [COL_BITS-1:0] msk_q;
    logic                fp_q, cl3_q, wbm_q;
    logic                bst_q, brd_q, bap_q, bfp_q;
    logic [1:0]          bba_q;
    logic [COL_BITS-1:0] bcol_q, left_q;
    logic [2:0]          pv_q;
    logic [MEM_AW-1:0]   pa_q [3];
    logic [1:0]          dm1_q, om_q;
    logic                oe_q;
    logic [15:0]         od_q;

    logic [3:0]          cmd;
    logic                is_act, is_rd, is_wr, is_pre, is_lmr, is_bst;
    logic                rw_cmd, pre_hit, cont, iss, iss_rd, single, more, ap, close_ap;
    logic [1:0]          iss_ba, osel;
    logic [COL_BITS-1:0] iss_col, ncol, bl_dec;
    logic [MEM_AW-1:0]   iss_idx;

    assign cmd    = {Cs_n, Ras_n, Cas_n, We_n};
    assign is_act = cmd == CMD_ACT;
    assign is_rd  = cmd == CMD_RD;
    assign is_wr  = cmd == CMD_WR;
    assign is_pre = cmd == CMD_PRE;
    assign is_lmr = cmd == CMD_LMR;
    assign is_bst = cmd == CMD_BST;

    // A column access only counts when its bank is open; it then pre-empts any running burst
    assign rw_cmd  = (is_rd || is_wr) && open_q[Ba];
    assign pre_hit = is_pre && (Addr[10] || Ba == bba_q);
    assign cont    = bst_q && !rw_cmd && !is_bst && !pre_hit;
    assign iss     = rw_cmd || cont;
    assign iss_rd  = rw_cmd ? is_rd : brd_q;
    assign iss_ba  = rw_cmd ? Ba : bba_q;
    assign iss_col = rw_cmd ? Addr[COL_BITS-1:0] : bcol_q;
    assign iss_idx = MEM_AW'({iss_ba, row_q[iss_ba], iss_col});
    assign ncol    = (iss_col & ~msk_q) | ((iss_col + 1'b1) & msk_q);
    assign single  = is_wr && wbm_q;
    assign more    = rw_cmd ? (!single && (fp_q || msk_q != '0)) : (bfp_q || left_q != COL_BITS'(1));
    assign ap      = rw_cmd ? Addr[10] : bap_q;
    assign close_ap = iss && !more && ap;
    assign osel    = cl3_q ? 2'd2 : 2'd1;
    assign bl_dec  = Addr[2:0] == 3'b001 ? COL_BITS'(1) :
                     Addr[2:0] == 3'b010 ? COL_BITS'(3) :
                     Addr[2:0] == 3'b011 ? COL_BITS'(7) :
                     Addr[2:0] == 3'b111 ? '1 : '0;

    assign Dq[7:0]  = (oe_q && !om_q[0]) ? od_q[7:0]  : 8'hzz;
    assign Dq[15:8] = (oe_q && !om_q[1]) ? od_q[15:8] : 8'hzz;

    // Bank open flags: activate, precharge (single/all) and auto-precharge at burst end
    always_comb begin
        open_d = open_q;
        if (is_act) open_d[Ba] = 1'b1;
        if (is_pre) open_d = Addr[10] ? 4'b0000 : open_q & ~(4'b0001 << Ba);
        if (close_ap) open_d[iss_ba] = 1'b0;
    end

    // Storage writes sit outside the reset domain so reset never disturbs contents
    always_ff @(posedge Clk) begin
        if (Rst_n && Cke && iss && !iss_rd) begin
            if (!Dqm[0]) mem_q[iss_idx][7:0]  <= Dq[7:0];
            if (!Dqm[1]) mem_q[iss_idx][15:8] <= Dq[15:8];
        end
    end

    // Command state, burst engine, CAS-latency pipeline and DQM-delayed output register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            open_q <= '0;
            for (int i = 0; i < 4; i++) row_q[i] <= '0;
            msk_q  <= '0;
            fp_q   <= 1'b0;
            cl3_q  <= 1'b0;
            wbm_q  <= 1'b0;
            bst_q  <= 1'b0;
            brd_q  <= 1'b0;
            bap_q  <= 1'b0;
            bfp_q  <= 1'b0;
            bba_q  <= '0;
            bcol_q <= '0;
            left_q <= '0;
            pv_q   <= '0;
            for (int i = 0; i < 3; i++) pa_q[i] <= '0;
            dm1_q  <= '0;
            om_q   <= '0;
            oe_q   <= 1'b0;
            od_q   <= '0;
        end else if (Cke) begin
            open_q <= open_d;
            if (is_act && !open_q[Ba]) row_q[Ba] <= Addr[ROW_BITS-1:0];
            if (is_lmr && open_q == '0) begin
                msk_q <= bl_dec;
                fp_q  <= Addr[2:0] == 3'b111;
                cl3_q <= Addr[6:4] == 3'd3;
                wbm_q <= Addr[9];
            end
            bst_q <= iss && more;
            if (rw_cmd) begin
                brd_q <= is_rd;
                bba_q <= Ba;
                bap_q <= Addr[10];
                bfp_q <= fp_q && !single;
            end
            if (iss) begin
                bcol_q <= ncol;
                left_q <= rw_cmd ? msk_q : left_q - 1'b1;
            end
            pv_q    <= {pv_q[1:0], iss && iss_rd};
            pa_q[0] <= iss_idx;
            pa_q[1] <= pa_q[0];
            pa_q[2] <= pa_q[1];
            dm1_q   <= Dqm;
            om_q    <= dm1_q;
            oe_q    <= pv_q[osel] && !(rw_cmd && is_wr);
            od_q    <= mem_q[pa_q[osel]];
        end
    end
endmodule

// File: tb/tb_mt48lc16m16a2.sv
// tb_mt48lc16m16a2: directed plus randomized command sequences checked against a per-edge SDRAM reference model
module tb_mt48lc16m16a2;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000, BST = 4'b0110;

    logic        clk = 1'b0, rst_n = 1'b0, cke = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = '0, dqm = '0;
    logic [12:0] addr = '0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;
    wire  [15:0] dq;
    int          checks = 0, failures = 0;

    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    always #5 clk = ~clk;

    mt48lc16m16a2 dut (
        .Clk(clk), .Rst_n(rst_n), .Cke(cke), .Cs_n(cs_n), .Ras_n(ras_n), .Cas_n(cas_n),
        .We_n(we_n), .Ba(ba), .Addr(addr), .Dqm(dqm), .Dq(dq)
    );

    int          cyc = 0;
    bit          m_open [4];
    int          m_row [4];
    int          m_bl, m_cl;
    bit          m_wbm;
    bit          b_act, b_rd, b_ap;
    int          b_bank, b_col0, b_k, b_len;
    logic [15:0] mm [int];
    int          sa [int];
    logic [1:0]  dqh [int];
    bit          cur_v;
    logic [15:0] cur_d;
    logic [1:0]  cur_m;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_open[i] = 0;
        m_bl = 1; m_cl = 2; m_wbm = 0; b_act = 0; cur_v = 0;
        sa.delete();
        dqh[cyc] = 2'b00;
    endtask

    // One enabled clock edge of the chip as seen from the pins
    task automatic model_edge(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                              input logic [1:0] m, input logic [15:0] d);
        int col, idx;
        bit any;
        logic [15:0] w;
        cyc++;
        dqh[cyc] = m;
        cur_v = sa.exists(cyc);
        if (cur_v) cur_d = mm.exists(sa[cyc]) ? mm[sa[cyc]] : 16'hxxxx;
        cur_m = dqh[cyc-1];
        any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        if ((c == RD || c == WR) && m_open[b]) begin
            b_act = 1; b_rd = (c == RD); b_bank = b; b_col0 = a % 512; b_k = 0;
            b_len = (c == WR && m_wbm) ? 1 : m_bl; b_ap = a[10];
            if (c == WR) cur_v = 0;
        end else if (c == BST) begin
            b_act = 0;
        end else if (c == PRE) begin
            if (b_act && (a[10] || b == b_bank)) b_act = 0;
            for (int i = 0; i < 4; i++) if (a[10] || i == b) m_open[i] = 0;
        end else if (c == ACT && !m_open[b]) begin
            m_open[b] = 1; m_row[b] = a;
        end else if (c == LMR && !any) begin
            m_bl = a[2:0] == 3'd1 ? 2 : a[2:0] == 3'd2 ? 4 : a[2:0] == 3'd3 ? 8 : a[2:0] == 3'd7 ? 512 : 1;
            m_cl = a[6:4] == 3'd3 ? 3 : 2;
            m_wbm = a[9];
        end
        if (b_act) begin
            col = b_col0 - b_col0 % b_len + (b_col0 + b_k) % b_len;
            idx = (b_bank * (1 << 22) + m_row[b_bank] * 512 + col) % 65536;
            if (b_rd) sa[cyc + m_cl] = idx;
            else begin
                w = mm.exists(idx) ? mm[idx] : 16'h0000;
                if (!m[0]) w[7:0] = d[7:0];
                if (!m[1]) w[15:8] = d[15:8];
                mm[idx] = w;
            end
            b_k++;
            if (b_len != 512 && b_k == b_len) begin
                b_act = 0;
                if (b_ap) m_open[b_bank] = 0;
            end
        end
    endtask

    task automatic check_dq(input string tag, input logic drv, input logic [15:0] d);
        logic [15:0] e;
        e = 16'hzzzz;
        if (cur_v && !cur_m[0]) e[7:0] = cur_d[7:0];
        if (cur_v && !cur_m[1]) e[15:8] = cur_d[15:8];
        if (drv) e = d;
        checks++;
        assert (dq === e) else begin
            failures++;
            $error("FAIL %s cyc=%0d dq=%h expected=%h", tag, cyc, dq, e);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic [1:0] m,
                        input logic drv, input logic [15:0] d, input logic ke, input string tag);
        @(negedge clk);
        {cs_n, ras_n, cas_n, we_n} = c; ba = b; addr = a; dqm = m; tb_oe = drv; tb_dq = d; cke = ke;
        @(posedge clk);
        if (ke) model_edge(c, b, a, m, d);
        #1 check_dq(tag, drv, d);
    endtask

    task automatic op(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input string tag);
        step(c, b, a, 2'b00, 1'b0, 16'h0000, 1'b1, tag);
    endtask

    task automatic nops(input int n, input bit rdm, input string tag);
        for (int i = 0; i < n; i++)
            step(NOP, 2'b00, 13'h0, rdm ? 2'($urandom_range(0, 3)) : 2'b00, 1'b0, 16'h0, 1'b1, tag);
    endtask

    task automatic wr_burst(input logic [1:0] b, input logic [12:0] a, input int n, input logic [15:0] d0,
                            input bit rnd, input string tag);
        for (int k = 0; k < n; k++)
            step(k == 0 ? WR : NOP, b, k == 0 ? a : 13'h0, 2'b00, 1'b1,
                 rnd ? 16'($urandom) : d0 + 16'(k), 1'b1, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_dq(tag, 1'b0, 16'h0);
        @(negedge clk);
        {cs_n, ras_n, cas_n, we_n} = NOP; tb_oe = 1'b0; dqm = 2'b00; cke = 1'b1;
        @(posedge clk);
        #1 check_dq(tag, 1'b0, 16'h0);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 check_dq("reset_z", 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        op(LMR, 0, 13'h023, "lmr_bl8_cl2");
        op(ACT, 0, 13'd5, "act_b0r5");
        op(REF, 0, 13'h0, "ref_ignored");
        wr_burst(0, 13'd0, 8, 16'h1000, 0, "wr_bl8");
        op(NOP, 0, 13'h0, "gap");
        op(RD, 0, 13'd0, "rd_bl8_cl2");
        nops(10, 0, "rd_bl8_cl2");

        op(PRE, 0, 13'h400, "pre_all");
        op(LMR, 0, 13'h033, "lmr_bl8_cl3");
        op(ACT, 0, 13'd5, "act_b0r5");
        op(RD, 0, 13'd6, "rd_wrap_cl3");
        nops(11, 0, "rd_wrap_cl3");

        op(PRE, 0, 13'h400, "pre_all");
        op(LMR, 0, 13'h020, "lmr_bl1_cl2");
        op(ACT, 0, 13'd5, "act_b0r5");
        wr_burst(0, 13'd10, 1, 16'h1234, 0, "wr_1234");
        step(WR, 0, 13'd10, 2'b01, 1'b1, 16'hABCD, 1'b1, "wr_masked");
        op(RD, 0, 13'd10, "rd_masked");
        nops(4, 0, "rd_masked");
        op(RD, 0, 13'd10, "rd_dqm_hi");
        step(NOP, 0, 13'h0, 2'b10, 1'b0, 16'h0, 1'b1, "rd_dqm_hi");
        nops(4, 0, "rd_dqm_hi");

        op(RD, 1, 13'd0, "rd_closed");
        nops(4, 0, "rd_closed");
        op(PRE, 0, 13'h400, "pre_all");
        op(LMR, 0, 13'h023, "lmr_bl8_cl2");
        op(ACT, 0, 13'd5, "act_b0r5");
        op(RD, 0, 13'd0, "rd_pre_stop");
        op(NOP, 0, 13'h0, "rd_pre_stop");
        op(PRE, 0, 13'h400, "rd_pre_stop");
        nops(6, 0, "rd_pre_stop");

        op(ACT, 0, 13'd5, "act_b0r5");
        op(RD, 0, 13'd0, "rd_cke");
        nops(2, 0, "rd_cke");
        step(NOP, 0, 13'h0, 2'b00, 1'b0, 16'h0, 1'b0, "cke_freeze");
        step(NOP, 0, 13'h0, 2'b00, 1'b0, 16'h0, 1'b0, "cke_freeze");
        nops(8, 0, "rd_cke");

        op(RD, 0, 13'd0, "rd_bst");
        op(BST, 0, 13'h0, "rd_bst");
        nops(5, 0, "rd_bst");

        op(RD, 0, 13'd0, "rd_reset");
        nops(2, 0, "rd_reset");
        async_reset("reset_mid_burst");
        op(ACT, 0, 13'd5, "act_after_reset");
        op(RD, 0, 13'd3, "rd_default_mode");
        nops(4, 0, "rd_default_mode");

        op(PRE, 0, 13'h400, "pre_all");
        op(LMR, 0, 13'h022, "lmr_bl4_cl2");
        op(ACT, 1, 13'd7, "act_b1r7");
        wr_burst(1, 13'h404, 4, 16'h0, 1, "wr_autopre");
        op(NOP, 0, 13'h0, "gap");
        op(ACT, 1, 13'd7, "act_after_ap");
        op(RD, 1, 13'h405, "rd_autopre");
        nops(6, 0, "rd_autopre");
        op(RD, 1, 13'd4, "rd_after_ap");
        nops(4, 0, "rd_after_ap");

        op(LMR, 0, 13'h227, "lmr_fp_wbm");
        op(ACT, 2, 13'd9, "act_b2r9");
        for (int i = 0; i < 8; i++) wr_burst(2, 13'((510 + i) % 512), 1, 16'h0, 1, "wr_single");
        op(PRE, 0, 13'h400, "pre_all");
        op(LMR, 0, 13'h027, "lmr_fp");
        op(ACT, 2, 13'd9, "act_b2r9");
        op(RD, 2, 13'd510, "rd_fullpage");
        nops(5, 0, "rd_fullpage");
        op(BST, 0, 13'h0, "rd_fullpage");
        nops(5, 0, "rd_fullpage");

        for (int it = 0; it < 8; it++) begin
            int code, cl, b, row, col;
            code = $urandom_range(0, 3);
            cl   = $urandom_range(2, 3);
            b    = $urandom_range(0, 3);
            row  = $urandom_range(0, 8191);
            col  = $urandom_range(0, 511);
            op(PRE, 0, 13'h400, "rnd_pre");
            op(LMR, 0, 13'(cl * 16 + code), "rnd_lmr");
            op(ACT, 2'(b), 13'(row), "rnd_act");
            wr_burst(2'(b), 13'(col), 1 << code, 16'h0, 1, "rnd_wr");
            op(NOP, 0, 13'h0, "rnd_gap");
            step(RD, 2'(b), 13'(col), 2'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b1, "rnd_rd");
            nops((1 << code) + 5, 1, "rnd_rd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mt48lc16m16a2.md
MT48LC16M16A2 -- requirements
Module: mt48lc16m16a2

Interface
REQ-001 SHALL have parameter COL_BITS, default 9, column address width (A[COL_BITS-1:0]).
REQ-002 SHALL have parameter ROW_BITS, default 13, row address width.
REQ-003 SHALL have parameter MEM_AW, default 16, log2 of storage depth in 16-bit words.
REQ-004 SHALL have port Clk  input  1  clock; all commands sampled on rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Cke  input  1  clock enable; when 0 at an edge, that edge is ignored (no command, burst frozen).
REQ-007 SHALL have ports Cs_n, Ras_n, Cas_n, We_n  input  1 each  command lines, active-low.
REQ-008 SHALL have port Ba  input  2  bank address.
REQ-009 SHALL have port Addr  input  13  row/column/mode address; Addr[10] = auto-precharge / all-banks flag.
REQ-010 SHALL have port Dqm  input  2  byte mask; bit0 -> Dq[7:0], bit1 -> Dq[15:8].
REQ-011 SHALL have port Dq  inout  16  data; driven only while read data valid, else high-Z.

Function
REQ-012 SHALL decode {Cs_n,Ras_n,Cas_n,We_n}: 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 LOAD MODE, 0110 BURST TERMINATE.
REQ-013 SHALL keep per bank an open flag and open-row register; ACTIVE sets flag, latches Addr[ROW_BITS-1:0]; ACTIVE to an open bank SHALL be ignored.
REQ-014 SHALL close bank Ba on PRECHARGE with Addr[10]=0, all banks with Addr[10]=1; a burst on a closed bank SHALL stop at that edge.
REQ-015 SHALL treat AUTO REFRESH as no-op on storage; SHALL ignore it if any bank open.
REQ-016 SHALL on LOAD MODE (all banks closed) latch: Addr[2:0] burst length (000=1, 001=2, 010=4, 011=8, 111=full page 2^COL_BITS; others -> 1), Addr[6:4] CAS latency (2 or 3; others -> 2), Addr[9] write burst mode (1 = single-location writes); Addr[3] ignored, bursts always sequential.
REQ-017 SHALL form word index = {Ba, row, col} truncated to low MEM_AW bits (aliasing allowed).
REQ-018 SHALL ignore READ/WRITE to a closed bank.
REQ-019 READ: start column Addr[COL_BITS-1:0]; word k SHALL be driven on Dq from the edge CL+k after the READ edge until the next edge (valid at edge CL+k+1 sampling); column increments modulo BL within the BL-aligned block.
REQ-020 Read masking: Dqm sampled at edge n SHALL tri-state the corresponding byte of data for edge n+2 (2-cycle latency).
REQ-021 WRITE: word k SHALL be sampled from Dq on edge k after WRITE (k=0 is the command edge); byte written only if its Dqm bit is 0 at that edge (0 latency); same column-wrap rule; write burst mode 1 -> length 1.
REQ-022 A new READ or WRITE SHALL terminate any burst in progress; read data already scheduled by pipeline SHALL not be cut short for a later WRITE except Dq SHALL be released on the WRITE edge.
REQ-023 BURST TERMINATE SHALL end the current burst; read words already in the CL pipeline still output.
REQ-024 Addr[10]=1 on READ/WRITE SHALL close the bank when its burst completes.
REQ-025 Timing parameters (tRCD, tRP, tRC, tMRD) SHALL not be checked; commands legal by REQ-013..018 take effect immediately.
REQ-026 Full-page bursts SHALL wrap continuously until terminated.

Reset
REQ-027 Rst_n=0 SHALL immediately: close all banks, cancel bursts and read pipeline, release Dq to high-Z, set mode to BL=1, CL=2, write burst mode 0.
REQ-028 Storage contents SHALL not be altered by reset.
REQ-029 Reset deassertion SHALL take effect at the next rising Clk edge.

Verification
REQ-030 LOAD MODE Addr=0x023 (BL8, CL2), ACTIVE bank0 row5, WRITE col 0 with data 0x1000..0x1007 -> READ col 0 returns 0x1000..0x1007 starting edge 2 after READ.
REQ-031 Same with CL3 (Addr=0x033) -> first word appears one edge later; READ col 6 BL8 returns words in order 6,7,0,1,...,5.
REQ-032 WRITE 0xABCD with Dqm=01 over existing 0x1234 -> readback 0xAB34; READ with Dqm=10 two edges before word -> Dq[15:8]=Z.
REQ-033 READ on a closed bank -> Dq stays high-Z; PRECHARGE Addr[10]=1 mid read burst -> burst stops, following words Z.
REQ-034 Rst_n low during a read burst -> Dq high-Z immediately; after release, READ without LOAD MODE returns single word at CL2.
REQ-035 BURST TERMINATE one edge after a BL8 READ at CL2 -> exactly 1 word output.
